spi_master_mc: RTL
==================

Name: spi_master_mc

Overview:
Parametrised multi-chip-select SPI master. It is the successor to the fixed-rate, write-only, single-CS 16-bit shifter.
- Adds programmable SCLK divider, all four CPOL/CPHA modes, a ready/valid input handshake, per-frame chip-select selection and an enforced inter-frame CS gap.
- Optional: MISO readback.
- Sits between control logic (DAC/attenuator/PLL setting registers) and the board SPI pins.

Parameters:
DATA_SIZE, 16, bits per frame, MSB first; legal range >= 2.
NUM_CS, 2, number of chip-select outputs; legal range >= 1.
CLK_DIV, 2, clk cycles per SCLK half-period; legal range >= 1, 0 is an elaboration error.
CS_GAP, 2, minimum clk cycles all CS stay high between frames; legal range >= 0.
CPOL, 0, SCLK idle level.
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
in_valid  in  1  frame request
in_ready  out  1  master can accept a frame
in_data  in  DATA_SIZE  frame to transmit
in_cs_sel  in  CSW = max(1, clog2(NUM_CS))  index of target chip select
busy  out  1  frame or gap in progress
spi_clr_l  out  1  active-low bus clear
spi_cs_l  out  NUM_CS  active-low chip selects
spi_sclk  out  1  SPI clock
spi_mosi  out  1  SPI data out
spi_miso  in  1  SPI data in
rd_valid  out  1  readback word valid, one-cycle pulse
rd_data  out  DATA_SIZE  readback word

Behaviour:
- Reset values, applied on the clk edge where reset=1:
  - in_ready=0, busy=0, spi_clr_l=0, spi_cs_l=all 1, spi_sclk=CPOL, spi_mosi=0, rd_valid=0, rd_data=0.
  - State=IDLE.
- After reset deasserts:
  - spi_clr_l=1 from the first clk edge with reset=0.
  - in_ready=1 from that same edge.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE. With CS_GAP=0, HOLD goes directly to IDLE.
- IDLE:
  - in_ready=1, busy=0.
  - Accept on the edge where in_valid && in_ready (cycle 0): latch in_data and in_cs_sel.
  - in_ready=0 and busy=1 from cycle 1.
  - in_data/in_cs_sel changes after acceptance have no effect.
- SETUP (CLK_DIV cycles starting at cycle 1):
  - spi_cs_l[sel]=0, all other CS bits stay 1.
  - spi_sclk=CPOL.
  - CPHA=0: spi_mosi=bit DATA_SIZE-1 during SETUP.
- SHIFT:
  - SCLK edge k (k=1..2*DATA_SIZE) occurs at cycle 1+k*CLK_DIV; odd k = leading edge, even k = trailing edge.
  - CPHA=0: MOSI advances to the next bit on each trailing edge except the last.
  - CPHA=1: MOSI presents the next bit on each leading edge; the first leading edge presents the MSB.
  - Bit counter width clog2(DATA_SIZE)+1; no wrap.
- HOLD: SCLK stays at CPOL for CLK_DIV cycles; spi_cs_l goes all 1 at cycle 1+(2*DATA_SIZE+1)*CLK_DIV.
- GAP:
  - CS_GAP cycles with all CS high.
  - in_ready=1 exactly CS_GAP cycles after CS deasserts; busy drops on the same edge.
- Out-of-range in_cs_sel (>= NUM_CS): the frame is still clocked out and timed normally, but no CS bit asserts.
- in_valid held high continuously: back-to-back frames separated by exactly CS_GAP cycles of CS high plus the one IDLE accept cycle.
- Reset mid-frame:
  - Frame is abandoned and all outputs take their reset values on the next edge.
  - No rd_valid for the abandoned frame.
- spi_mosi after a frame: holds the last driven bit until the next SETUP.

Optional Feature:
Macro SPI_MASTER_MISO_EN.
- Defined:
  - spi_miso is sampled on every sampling edge (odd k for CPHA=0, even k for CPHA=1) into an RX shift register, MSB first.
  - On the edge that deasserts CS, rd_data <= assembled word and rd_valid=1 for exactly one cycle.
  - rd_data holds its value until the next completed frame.
- Undefined:
  - spi_miso is ignored; rd_valid=0 and rd_data=0 permanently.
  - No RX register is synthesised.
  - Ports remain present.

Test Plan:
1. Reset, then 0xA5C3 to cs_sel=1 (CLK_DIV=1, CS_GAP=2, mode 0) -> ready on the first edge after reset; CS[1] low at cycle 1; 16 rising edges at cycles 2,4,...,32 with MOSI bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; CS high at cycle 34; in_ready=1 at cycle 36; CS[0] stays high throughout.
2. Mode 3 (CPOL=1, CPHA=1), CLK_DIV=3, data 0x8001 -> SCLK idles 1; leading (falling) edge at cycle 4; MOSI=1 from cycle 4; last edge at cycle 97; CS high at cycle 100.
3. in_valid held high with two frames 0x0001 and 0xFFFF -> exactly CS_GAP+1 cycles with all CS high between frames; no frame lost.
4. reset asserted at cycle 10 of a frame -> all CS high, SCLK=CPOL, spi_clr_l=0 on the next edge; no rd_valid; clean frame afterwards.
5. With SPI_MASTER_MISO_EN defined, MISO driven as loopback of MOSI, tx 0x3C5A -> rd_valid single pulse on the CS-deassert edge with rd_data=0x3C5A. Without the macro, rd_valid stays 0.
6. in_cs_sel=3 with NUM_CS=3 -> full-length SCLK burst, all CS high throughout, in_ready returns at normal timing.

Source files
------------

// File: rtl/spi_master_mc.sv
// Multi-chip-select SPI master: programmable SCLK divider, CPOL/CPHA modes, ready/valid input, CS gap.
// Define SPI_MASTER_MISO_EN to enable MISO readback on rd_valid/rd_data.
module spi_master_mc #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned NUM_CS    = 2,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned CS_GAP    = 2,
  parameter int unsigned CPOL      = 0,
  parameter int unsigned CPHA      = 0,
  localparam int unsigned CSW      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic [CSW-1:0]       in_cs_sel,
  output logic                 busy,
  output logic                 spi_clr_l,
  output logic [NUM_CS-1:0]    spi_cs_l,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic                 rd_valid,
  output logic [DATA_SIZE-1:0] rd_data
);

  localparam int unsigned CNT_MAX  = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1) + 1;
  localparam int unsigned BIT_W    = $clog2(DATA_SIZE) + 1;
  localparam int unsigned GAP_LAST = (CS_GAP > 0) ? CS_GAP - 1 : 0;

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("spi_master_mc: CLK_DIV must be >= 1");
  end
  if (DATA_SIZE < 2) begin : g_bad_data_size
    $error("spi_master_mc: DATA_SIZE must be >= 2");
  end
  if (NUM_CS < 1) begin : g_bad_num_cs
    $error("spi_master_mc: NUM_CS must be >= 1");
  end

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     div_cnt, div_cnt_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic                 phase, phase_n;
  logic [DATA_SIZE-1:0] tx_sr, tx_sr_n;
  logic                 in_ready_n, busy_n, sclk_n, mosi_n;
  logic [NUM_CS-1:0]    cs_l_n;
  logic                 div_last;
  logic                 sample_c, done_c;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      phase     <= 1'b0;
      tx_sr     <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      spi_clr_l <= 1'b0;
      spi_cs_l  <= '1;
      spi_sclk  <= 1'(CPOL);
      spi_mosi  <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_cnt_n;
      bit_cnt   <= bit_cnt_n;
      phase     <= phase_n;
      tx_sr     <= tx_sr_n;
      in_ready  <= in_ready_n;
      busy      <= busy_n;
      spi_clr_l <= 1'b1;
      spi_cs_l  <= cs_l_n;
      spi_sclk  <= sclk_n;
      spi_mosi  <= mosi_n;
    end
  end

  // Next-state and next-output logic; phase=0 means the next SCLK edge is a leading edge
  always_comb begin
    state_n    = state;
    div_cnt_n  = div_cnt;
    bit_cnt_n  = bit_cnt;
    phase_n    = phase;
    tx_sr_n    = tx_sr;
    in_ready_n = in_ready;
    busy_n     = busy;
    cs_l_n     = spi_cs_l;
    sclk_n     = spi_sclk;
    mosi_n     = spi_mosi;
    sample_c   = 1'b0;
    done_c     = 1'b0;
    div_last   = (div_cnt == CNT_W'(CLK_DIV - 1));
    case (state)
      IDLE: begin
        in_ready_n = 1'b1;
        busy_n     = 1'b0;
        if (in_valid && in_ready) begin
          state_n    = SETUP;
          div_cnt_n  = '0;
          bit_cnt_n  = '0;
          phase_n    = 1'b0;
          in_ready_n = 1'b0;
          busy_n     = 1'b1;
          cs_l_n     = '1;
          for (int i = 0; i < int'(NUM_CS); i++) begin
            if (in_cs_sel == CSW'(i)) cs_l_n[i] = 1'b0;
          end
          if (CPHA == 0) begin
            mosi_n  = in_data[DATA_SIZE-1];
            tx_sr_n = in_data << 1;
          end else begin
            tx_sr_n = in_data;
          end
        end
      end
      SETUP, SHIFT: begin
        if (div_last) begin
          div_cnt_n = '0;
          sclk_n    = ~spi_sclk;
          state_n   = SHIFT;
          if (!phase) begin
            phase_n = 1'b1;
            if (CPHA != 0) begin
              mosi_n  = tx_sr[DATA_SIZE-1];
              tx_sr_n = tx_sr << 1;
            end else begin
              sample_c = 1'b1;
            end
          end else begin
            phase_n   = 1'b0;
            bit_cnt_n = bit_cnt + BIT_W'(1);
            if (CPHA != 0) begin
              sample_c = 1'b1;
            end else if (bit_cnt != BIT_W'(DATA_SIZE - 1)) begin
              mosi_n  = tx_sr[DATA_SIZE-1];
              tx_sr_n = tx_sr << 1;
            end
            if (bit_cnt == BIT_W'(DATA_SIZE - 1)) state_n = HOLD;
          end
        end else begin
          div_cnt_n = div_cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (div_last) begin
          div_cnt_n = '0;
          cs_l_n    = '1;
          done_c    = 1'b1;
          if (CS_GAP == 0) begin
            state_n    = IDLE;
            in_ready_n = 1'b1;
            busy_n     = 1'b0;
          end else begin
            state_n = GAP;
          end
        end else begin
          div_cnt_n = div_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (div_cnt == CNT_W'(GAP_LAST)) begin
          state_n    = IDLE;
          in_ready_n = 1'b1;
          busy_n     = 1'b0;
        end else begin
          div_cnt_n = div_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef SPI_MASTER_MISO_EN
  logic [DATA_SIZE-1:0] rx_sr;

  // Receive shift register; word is published on the CS-deassert edge
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sr    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= done_c;
      if (sample_c) rx_sr <= {rx_sr[DATA_SIZE-2:0], spi_miso};
      if (done_c) rd_data <= rx_sr;
    end
  end
`else
  logic rx_unused;
  assign rx_unused = ^{spi_miso, sample_c, done_c};
  assign rd_valid  = 1'b0;
  assign rd_data   = '0;
`endif

endmodule
